// File: rtl/dt_res_packer.sv
// Scans a 128x128 8-bit distance map out of the result RAM, thresholds each pixel
// and repacks the bits MSB-first into 1024 16-bit sti-format words, counting 1-bits.
module dt_res_packer #(
   parameter logic [7:0] THRESH     = 8'd1,
   parameter bit         BORDER_CLR = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        sti_wr,
   output logic [9:0]  sti_addr,
   output logic [15:0] sti_do,
   output logic [14:0] obj_cnt,
   output logic        done,
   output logic [1:0]  state_dbg
);

   // Strobe semantics: res_di answers the res_addr registered one cycle earlier
   // (no back-pressure); sti_wr is a one-cycle write strobe qualifying sti_addr/sti_do.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [13:0] PIX_LAST = 14'h3FFF;

   state_t      state;
   state_t      state_nxt;
   logic        cap_valid;
   logic [14:0] shift;
   logic        last_pix;
   logic        pix_ge;
   logic        border;
   logic        pix_bit;

   // THRESH=0 accepts every pixel; resolving it at elaboration keeps the compare meaningful.
   if (THRESH == 8'd0) begin : g_thr_zero
      assign pix_ge = 1'b1;
   end else begin : g_thr_cmp
      assign pix_ge = (res_di >= THRESH);
   end

   // The pixel being captured is the one res_addr pointed at in the previous cycle,
   // which is still the current res_addr value (it holds once it reaches the last pixel).
   assign border  = (res_addr[13:7] == 7'd0) || (res_addr[13:7] == 7'd127) ||
                    (res_addr[6:0]  == 7'd0) || (res_addr[6:0]  == 7'd127);
   assign pix_bit = pix_ge & ~(BORDER_CLR & border);

   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      last_pix  = 1'b0;
      case (state)
         IDLE: state_nxt = READ;
         READ: begin
            if (cap_valid && (res_addr == PIX_LAST)) begin
               last_pix  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_rd    <= 1'b0;
         res_addr  <= '0;
         sti_wr    <= 1'b0;
         sti_addr  <= '0;
         sti_do    <= '0;
         obj_cnt   <= '0;
         done      <= 1'b0;
         shift     <= '0;
         cap_valid <= 1'b0;
      end else begin
         sti_wr <= 1'b0;
         case (state)
            IDLE: begin
               res_rd    <= 1'b1;
               res_addr  <= '0;
               cap_valid <= 1'b1;
            end
            READ: begin
               if (res_addr != PIX_LAST) res_addr <= res_addr + 14'd1;
               if (cap_valid) begin
                  shift   <= {shift[13:0], pix_bit};
                  obj_cnt <= obj_cnt + {14'd0, pix_bit};
                  if (res_addr[3:0] == 4'hF) begin
                     sti_wr   <= 1'b1;
                     sti_addr <= res_addr[13:4];
                     sti_do   <= {shift, pix_bit};
                  end
               end
               if (last_pix) begin
                  res_rd    <= 1'b0;
                  cap_valid <= 1'b0;
               end
            end
            DONE:    done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
